// File: rtl/i2cm_byte_engine.sv
// i2cm_byte_engine: byte-level I2C master engine.
// Executes one command at a time (START, WRITE, READ, STOP) on an open-drain
// SCL/SDA pair, each bus phase split into four quarters of SCL_DIV_LEN clocks.
// Optional feature: define I2CM_CLK_STRETCH_EN to honour target clock stretching.
//
// Handshake: a command is accepted on any cycle with cmd_valid_i && cmd_ready_o;
// cmd_ready_o is high only while idle or holding the bus, so it drops the cycle
// after acceptance. Every accepted command yields exactly one rsp_valid_o pulse.
module i2cm_byte_engine #(
   parameter logic [7:0] SCL_DIV_LEN = 8'd50
) (
   input  logic       apb_pclk_i,
   input  logic       apb_presetn_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [1:0] cmd_op_i,
   input  logic [7:0] cmd_wdata_i,
   input  logic       cmd_last_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic       rsp_ack_o,
   output logic       rsp_err_o,
   output logic       busy_o,
   input  logic       i2c_scl_i,
   input  logic       i2c_sda_i,
   output logic       i2c_scl_oe,
   output logic       i2c_sda_oe,
   output logic [2:0] dbg_state
);

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_STOP  = 2'b11;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HOLD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_BIT   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0] state;
   logic [7:0] cnt;
   logic [1:0] qtr;
   logic [3:0] bit_cnt;
   logic [1:0] op_q;
   logic [6:0] wdata_q;
   logic       last_q;
   logic [7:0] rx_q;
   logic       err_pend;
   logic       ack_pend;
   logic       scl_oe_q;
   logic       sda_oe_q;
   logic       rsp_valid_q;
   logic       rsp_ack_q;
   logic       rsp_err_q;
   logic [7:0] rdata_q;
   logic       busy_q;

   logic       cmd_accept;
   logic       running;
   logic       advance;
   logic       last_cnt;
   logic       tick;

   assign cmd_ready_o = (state == S_IDLE) || (state == S_HOLD);
   assign cmd_accept  = cmd_valid_i && cmd_ready_o;
   assign running     = (state == S_START) || (state == S_BIT) || (state == S_STOP);
   assign last_cnt    = (cnt == (SCL_DIV_LEN - 8'd1));
   assign tick        = running && advance && last_cnt;

`ifdef I2CM_CLK_STRETCH_EN
   // The quarter in which the engine releases SCL waits for the line to read
   // high; once seen, the quarter counts normally even if SCL drops again.
   logic stretch_qtr;
   logic scl_seen;

   assign stretch_qtr = ((state == S_BIT) && (qtr == 2'd2)) ||
                        (((state == S_START) || (state == S_STOP)) && (qtr == 2'd1));
   assign advance     = !stretch_qtr || i2c_scl_i || scl_seen;

   // Remember that SCL has been seen high within the current stretch quarter
   always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
      if (!apb_presetn_i) begin
         scl_seen <= 1'b0;
      end else if (tick || cmd_accept) begin
         scl_seen <= 1'b0;
      end else if (stretch_qtr && i2c_scl_i) begin
         scl_seen <= 1'b1;
      end
   end
`else
   logic unused_scl;
   assign unused_scl = i2c_scl_i;
   assign advance    = 1'b1;
`endif

   // Quarter timer: counts clocks within a quarter and steps the quarter index
   always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
      if (!apb_presetn_i) begin
         cnt <= 8'd0;
         qtr <= 2'd0;
      end else if (cmd_accept) begin
         cnt <= 8'd0;
         qtr <= 2'd0;
      end else if (running && advance) begin
         if (last_cnt) begin
            cnt <= 8'd0;
            qtr <= qtr + 2'd1;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   // Command FSM: sequences bus phases, drives the lines and builds the response
   always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
      if (!apb_presetn_i) begin
         state       <= S_IDLE;
         bit_cnt     <= 4'd0;
         op_q        <= OP_START;
         wdata_q     <= 7'd0;
         last_q      <= 1'b0;
         rx_q        <= 8'd0;
         err_pend    <= 1'b0;
         ack_pend    <= 1'b0;
         scl_oe_q    <= 1'b0;
         sda_oe_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_ack_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= 8'd0;
         busy_q      <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_ack_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         case (state)
            S_IDLE, S_HOLD: begin
               if (cmd_valid_i) begin
                  op_q     <= cmd_op_i;
                  wdata_q  <= cmd_wdata_i[6:0];
                  last_q   <= cmd_last_i;
                  bit_cnt  <= 4'd0;
                  err_pend <= 1'b0;
                  ack_pend <= 1'b0;
                  if (cmd_op_i == OP_START) begin
                     state    <= S_START;
                     sda_oe_q <= 1'b0;
                  end else if (state == S_IDLE) begin
                     // Data or STOP without owning the bus: reject, touch nothing
                     state    <= S_DONE;
                     err_pend <= 1'b1;
                  end else if (cmd_op_i == OP_STOP) begin
                     state    <= S_STOP;
                     scl_oe_q <= 1'b1;
                     sda_oe_q <= 1'b1;
                  end else begin
                     // First bit's SDA is set on entry while SCL is still low
                     state    <= S_BIT;
                     scl_oe_q <= 1'b1;
                     sda_oe_q <= (cmd_op_i == OP_WRITE) ? ~cmd_wdata_i[7] : 1'b0;
                  end
               end
            end
            S_START: begin
               if (tick) begin
                  case (qtr)
                     2'd0:    scl_oe_q <= 1'b0;
                     2'd1:    sda_oe_q <= 1'b1;
                     2'd2:    scl_oe_q <= 1'b1;
                     default: state    <= S_DONE;
                  endcase
               end
            end
            S_BIT: begin
               if (tick) begin
                  case (qtr)
                     2'd0: ;
                     2'd1: scl_oe_q <= 1'b0;
                     2'd2: begin
                        if (bit_cnt < 4'd8) begin
                           rx_q <= {rx_q[6:0], i2c_sda_i};
                        end else begin
                           ack_pend <= (op_q == OP_WRITE) && !i2c_sda_i;
                        end
                     end
                     default: begin
                        // SCL goes low again; either set up the next bit or finish
                        scl_oe_q <= 1'b1;
                        if (bit_cnt == 4'd8) begin
                           state <= S_DONE;
                        end else begin
                           bit_cnt <= bit_cnt + 4'd1;
                           if (bit_cnt == 4'd7) begin
                              sda_oe_q <= (op_q == OP_READ) ? ~last_q : 1'b0;
                           end else if (op_q == OP_WRITE) begin
                              sda_oe_q <= ~wdata_q[6];
                              wdata_q  <= {wdata_q[5:0], 1'b0};
                           end else begin
                              sda_oe_q <= 1'b0;
                           end
                        end
                     end
                  endcase
               end
            end
            S_STOP: begin
               if (tick) begin
                  case (qtr)
                     2'd0:    scl_oe_q <= 1'b0;
                     2'd1:    sda_oe_q <= 1'b0;
                     2'd2:    ;
                     default: state    <= S_DONE;
                  endcase
               end
            end
            S_DONE: begin
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= err_pend;
               rsp_ack_q   <= ack_pend;
               if (err_pend) begin
                  state <= S_IDLE;
               end else begin
                  case (op_q)
                     OP_START: begin
                        state  <= S_HOLD;
                        busy_q <= 1'b1;
                     end
                     OP_STOP: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                     end
                     OP_READ: begin
                        state   <= S_HOLD;
                        rdata_q <= rx_q;
                     end
                     default: state <= S_HOLD;
                  endcase
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_ack_o   = rsp_ack_q;
   assign rsp_err_o   = rsp_err_q;
   assign busy_o      = busy_q;
   assign i2c_scl_oe  = scl_oe_q;
   assign i2c_sda_oe  = sda_oe_q;
   assign dbg_state   = state;

endmodule
